push_arbiter: RTL and testbench
===============================

# push_arbiter

Round-robin / fixed-priority arbiter that shares the single FIFO push port among `NREQ` requesters using a per-requester req/ack handshake with bounded bursts. It sits between the requesting agents and the FIFO push/full interface in the pilot top. It is configured and observed through the same 32-bit software register bus (`sw_we`/`sw_addr`/`sw_wdata`) used by the rest of the top.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ADDR_CTRL`, 32'h0000_0010: control register address.
- `ADDR_STAT`, 32'h0000_0014: status register address.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  per-requester request level; held while the requester has data.
- `ack`  out  NREQ  one-hot pulse; `ack[i]`=1 means requester i's word was pushed this cycle.
- `fifo_full`  in  1  FIFO cannot accept a push.
- `fifo_push`  out  1  push strobe to FIFO.
- `push_id`  out  $clog2(NREQ)  index of the requester being pushed; valid when `fifo_push`=1.
- `sw_we`  in  1  register write strobe.
- `sw_re`  in  1  register read strobe.
- `sw_addr`  in  32  register address.
- `sw_wdata`  in  32  register write data.
- `sw_rdata`  out  32  register read data, valid the cycle after `sw_re`.

## Operation
- CTRL (R/W): bit0 `en`; bit1 `mode` (0 = round-robin, 1 = fixed priority, lowest index wins); bits[15:8] `burst_len` (0 is treated as 1); bits[16+NREQ-1:16] `mask` (1 = requester allowed). Other bits read 0.
- STAT (RO; a write of any value clears the counter): bits[15:0] `push_cnt`, which wraps 16'hFFFF->0; bits[18:16] `owner`; bit31 `busy` (state is BURST).
- Eligible set E = `req & mask`.
- State IDLE: when `en`=1, E!=0 and `fifo_full`=0, select the winner. In RR mode the winner is the first eligible index at or after `rr_ptr`, modulo NREQ. In fixed mode it is the lowest eligible index. Then push (see Timing), set `owner` to the winner, set `beat` to 1, and go to BURST if `burst_len`>1. Otherwise stay in IDLE and set `rr_ptr`=winner+1.
- State BURST, evaluated in priority order:
  - `en`=0, `req[owner]`=0 or `mask[owner]`=0: no push; go to IDLE; `rr_ptr`=owner+1.
  - `fifo_full`=1: no push; stay in BURST; `beat` is unchanged.
  - Otherwise: push for `owner` and increment `beat`. If `beat`+1 == `burst_len`, go to IDLE with `rr_ptr`=owner+1.
- No requester is granted while another owns a burst. An `ack` is never asserted without `fifo_push`.
- `push_cnt` increments on every push. On a STAT write in the same cycle as a push, the clear wins and the result is 0.
- A CTRL write takes effect for decisions starting the cycle after the write. The write cycle itself uses the old value.

## Timing
- Reset values: `ack`=0, `fifo_push`=0, `push_id`=0, `sw_rdata`=0, CTRL=0 (disabled), `push_cnt`=0, `rr_ptr`=0, `owner`=0, state IDLE.
- All outputs are registered. Inputs sampled at edge N produce `fifo_push`/`ack`/`push_id` during cycle N+1, which is a 1-cycle grant latency.
- `fifo_full` is sampled in the same cycle as the push decision. The FIFO must tolerate one push decided on the last non-full sample.
- In BURST with continuous `req[owner]` and `fifo_full`=0, the block pushes every cycle, giving back-to-back `ack` pulses.
- Reset asserted mid-burst immediately clears all outputs and state. There is no partial completion.
- `sw_rdata` is registered: it reflects the addressed register one cycle after `sw_re`=1 and is held otherwise. Unmapped addresses read 0.

## Test plan
- Reset then idle: `req`=4'b1111 with CTRL=0 -> no `fifo_push` for 20 cycles; STAT reads 0.
- RR fairness: CTRL={mask=4'hF, burst_len=1, mode=0, en=1}, `req`=4'hF held -> `push_id` sequence 0,1,2,3,0,… one per cycle; after 8 cycles STAT `push_cnt`=8.
- Burst with stall: `burst_len`=4, `req`=4'b0010, `fifo_full` high for 2 cycles after the 2nd beat -> exactly 4 `ack[1]` pulses; gap of 2; `busy`=1 throughout, then 0.
- Early release: `burst_len`=8, `req[2]` drops after 3 pushes -> 3 pushes, return to IDLE; the next grant goes to index 3 when `req`=4'b1001.
- Fixed priority and mask: mode=1, mask=4'b1110, `req`=4'b1111 -> all pushes `push_id`=1; requester 0 gets no `ack`.
- Counter edge: preload via 65535 pushes, push again -> `push_cnt`=0; a STAT write coincident with a push -> `push_cnt`=0.

Source files
------------

// File: rtl/push_arbiter.sv
// Shares one FIFO push port among NREQ requesters. Round-robin or fixed-priority
// grants with bounded bursts; configured and observed over the 32-bit register bus.
module push_arbiter #(
  parameter int          NREQ      = 4,
  parameter logic [31:0] ADDR_CTRL = 32'h0000_0010,
  parameter logic [31:0] ADDR_STAT = 32'h0000_0014
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         ack,
  input  logic                    fifo_full,
  output logic                    fifo_push,
  output logic [$clog2(NREQ)-1:0] push_id,
  input  logic                    sw_we,
  input  logic                    sw_re,
  input  logic [31:0]             sw_addr,
  input  logic [31:0]             sw_wdata,
  output logic [31:0]             sw_rdata
);
  localparam int IW = $clog2(NREQ);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic            r_en, r_mode;
  logic [7:0]      r_blen;
  logic [NREQ-1:0] r_mask;
  logic [0:0]      r_state;
  logic [IW-1:0]   r_owner, r_rr;
  logic [7:0]      r_beat;
  logic [15:0]     r_cnt;

  logic [NREQ-1:0] w_elig;
  logic [7:0]      w_blen_eff;
  logic [IW-1:0]   w_win, w_idx;
  logic            w_win_vld;
  logic            w_push;
  logic [IW-1:0]   w_push_id, w_nxt_owner, w_nxt_rr;
  logic [0:0]      w_nxt_state;
  logic [7:0]      w_nxt_beat;
  logic            w_ctrl_wr, w_stat_wr;
  logic [31:0]     w_ctrl_rd, w_stat_rd;
  logic            w_unused;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] v);
    return (int'(v) == NREQ-1) ? '0 : v + 1'b1;
  endfunction

  assign w_elig     = req & r_mask;
  assign w_blen_eff = (r_blen == 8'd0) ? 8'd1 : r_blen;
  assign w_ctrl_wr  = sw_we && (sw_addr == ADDR_CTRL);
  assign w_stat_wr  = sw_we && (sw_addr == ADDR_STAT);
  assign w_ctrl_rd  = 32'({r_mask, r_blen, 6'b0, r_mode, r_en});
  assign w_stat_rd  = {r_state == S_BURST, 12'b0, 3'(r_owner), r_cnt};
  assign w_unused   = &{1'b0, sw_wdata[7:2], sw_wdata[31:16+NREQ]};

  // Scan order starts at rr_ptr in round-robin mode, at 0 in fixed mode.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_mode ? IW'(k) : IW'((int'(r_rr) + k) % NREQ);
      if (!w_win_vld && w_elig[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_id   = r_owner;
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_beat  = r_beat;
    w_nxt_rr    = r_rr;
    if (r_state == S_IDLE) begin
      if (r_en && w_win_vld && !fifo_full) begin
        w_push      = 1'b1;
        w_push_id   = w_win;
        w_nxt_owner = w_win;
        w_nxt_beat  = 8'd1;
        if (w_blen_eff > 8'd1) w_nxt_state = S_BURST;
        else                   w_nxt_rr    = inc_ptr(w_win);
      end
    end else if (!r_en || !req[r_owner] || !r_mask[r_owner]) begin
      // Owner vanished or was disabled: abandon the burst without a push.
      w_nxt_state = S_IDLE;
      w_nxt_rr    = inc_ptr(r_owner);
    end else if (!fifo_full) begin
      w_push     = 1'b1;
      w_nxt_beat = r_beat + 8'd1;
      if (r_beat + 8'd1 == w_blen_eff) begin
        w_nxt_state = S_IDLE;
        w_nxt_rr    = inc_ptr(r_owner);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_mode    <= 1'b0;
      r_blen    <= '0;
      r_mask    <= '0;
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr      <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
      ack       <= '0;
      fifo_push <= 1'b0;
      push_id   <= '0;
      sw_rdata  <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_owner   <= w_nxt_owner;
      r_rr      <= w_nxt_rr;
      r_beat    <= w_nxt_beat;
      fifo_push <= w_push;
      ack       <= w_push ? ({{(NREQ-1){1'b0}}, 1'b1} << w_push_id) : '0;
      if (w_push) push_id <= w_push_id;
      // Clear beats a coincident push.
      if (w_stat_wr)   r_cnt <= '0;
      else if (w_push) r_cnt <= r_cnt + 16'd1;
      if (w_ctrl_wr) begin
        r_en   <= sw_wdata[0];
        r_mode <= sw_wdata[1];
        r_blen <= sw_wdata[15:8];
        r_mask <= sw_wdata[16 +: NREQ];
      end
      if (sw_re) begin
        if (sw_addr == ADDR_CTRL)      sw_rdata <= w_ctrl_rd;
        else if (sw_addr == ADDR_STAT) sw_rdata <= w_stat_rd;
        else                           sw_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_push_arbiter.sv
// Directed and randomized bench for push_arbiter against a cycle-level
// behavioural model built from the arbitration rules.
module tb_push_arbiter;
  localparam logic [31:0] A_CTRL = 32'h0000_0010;
  localparam logic [31:0] A_STAT = 32'h0000_0014;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, ack;
  logic        fifo_full, fifo_push;
  logic [1:0]  push_id;
  logic        sw_we, sw_re;
  logic [31:0] sw_addr, sw_wdata, sw_rdata;

  push_arbiter #(.NREQ(4), .ADDR_CTRL(A_CTRL), .ADDR_STAT(A_STAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .fifo_full(fifo_full),
    .fifo_push(fifo_push), .push_id(push_id), .sw_we(sw_we), .sw_re(sw_re),
    .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_rdata(sw_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  // reference model state
  int m_en, m_mode, m_blen, m_mask, m_burst, m_owner, m_beat, m_rr, m_cnt;
  int e_push, e_ack, e_id;
  logic [31:0] e_rdata;
  // observed ack pulses per requester
  int obs_ack [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_blen = 0; m_mask = 0; m_burst = 0;
    m_owner = 0; m_beat = 0; m_rr = 0; m_cnt = 0;
    e_push = 0; e_ack = 0; e_id = 0; e_rdata = '0;
  endtask

  task automatic grant(input int w);
    e_push = 1; e_ack = 1 << w; e_id = w;
    m_cnt = (m_cnt + 1) % 65536;
  endtask

  // One clock edge of the specified behaviour, using the inputs now applied.
  task automatic model_step();
    int blen, elig, w, idx;
    blen = (m_blen == 0) ? 1 : m_blen;
    elig = int'(req) & m_mask;
    if (sw_re) begin
      if (sw_addr == A_CTRL)
        e_rdata = 32'(m_en) | (32'(m_mode) << 1) | (32'(m_blen) << 8) | (32'(m_mask) << 16);
      else if (sw_addr == A_STAT)
        e_rdata = 32'(m_cnt) | (32'(m_owner) << 16) | (32'(m_burst) << 31);
      else
        e_rdata = '0;
    end
    e_push = 0; e_ack = 0;
    if (m_burst == 0) begin
      if (m_en != 0 && elig != 0 && !fifo_full) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (m_mode != 0) ? k : (m_rr + k) % 4;
          if (w < 0 && ((elig >> idx) & 1) != 0) w = idx;
        end
        grant(w);
        m_owner = w; m_beat = 1;
        if (blen > 1) m_burst = 1;
        else          m_rr = (w + 1) % 4;
      end
    end else if (m_en == 0 || req[m_owner] == 1'b0 || ((m_mask >> m_owner) & 1) == 0) begin
      m_burst = 0; m_rr = (m_owner + 1) % 4;
    end else if (!fifo_full) begin
      grant(m_owner);
      m_beat++;
      if (m_beat == blen) begin m_burst = 0; m_rr = (m_owner + 1) % 4; end
    end
    if (sw_we && sw_addr == A_STAT) m_cnt = 0;
    if (sw_we && sw_addr == A_CTRL) begin
      m_en = int'(sw_wdata[0]); m_mode = int'(sw_wdata[1]);
      m_blen = int'(sw_wdata[15:8]); m_mask = int'(sw_wdata[19:16]);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("push", 32'(fifo_push), 32'(e_push));
    chk("ack", 32'(ack), 32'(e_ack));
    if (e_push != 0) chk("push_id", 32'(push_id), 32'(e_id));
    chk("rdata", sw_rdata, e_rdata);
    for (int i = 0; i < 4; i++) if (ack[i]) obs_ack[i]++;
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 4; i++) obs_ack[i] = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sw_we = 1'b1; sw_addr = a; sw_wdata = d;
    cyc();
    sw_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    sw_re = 1'b1; sw_addr = a;
    cyc();
    sw_re = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] d;
    req = '0; fifo_full = 1'b0; sw_we = 1'b0; sw_re = 1'b0;
    sw_addr = '0; sw_wdata = '0; rst_n = 1'b0;
    model_reset(); clr_obs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_push", 32'(fifo_push), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_id", 32'(push_id), 0);
    chk("rst_rdata", sw_rdata, 0);
    rst_n = 1'b1;

    // disabled arbiter ignores requests
    req = 4'hF;
    repeat (20) cyc();
    chk("idle_nopush", 32'(obs_ack[0] + obs_ack[1] + obs_ack[2] + obs_ack[3]), 0);
    rd(A_STAT);
    chk("idle_stat", sw_rdata, 0);

    // round-robin, burst 1
    wr(A_CTRL, 32'h000F_0101);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_seq", 32'(push_id), 32'(i % 4));
    end
    req = 4'h0;
    rd(A_STAT);
    chk("rr_cnt", 32'(sw_rdata[15:0]), 8);

    // burst of 4 with a 2-cycle stall after beat 2
    wr(A_CTRL, 32'h000F_0401);
    clr_obs();
    req = 4'b0010; sw_re = 1'b1; sw_addr = A_STAT;
    cyc(); cyc();
    fifo_full = 1'b1;
    cyc();
    cyc();
    chk("busy_stall", 32'(sw_rdata[31]), 1);
    fifo_full = 1'b0;
    cyc(); cyc();
    req = 4'b0000;
    cyc(); cyc();
    chk("busy_done", 32'(sw_rdata[31]), 0);
    chk("burst_acks", 32'(obs_ack[1]), 4);
    sw_re = 1'b0;

    // early release, then RR continues after the released owner
    wr(A_CTRL, 32'h000F_0801);
    clr_obs();
    req = 4'b0100;
    repeat (3) cyc();
    req = 4'b1001;
    cyc();
    g = 0;
    do begin cyc(); g++; end while (!fifo_push && g < 5);
    chk("rel_push", 32'(fifo_push), 1);
    chk("rel_next_id", 32'(push_id), 3);
    chk("rel_cnt2", 32'(obs_ack[2]), 3);
    req = 4'b0000;
    cyc(); cyc();

    // fixed priority with requester 0 masked out
    wr(A_CTRL, 32'h000E_0103);
    clr_obs();
    req = 4'hF;
    repeat (10) cyc();
    chk("fix_ack0", 32'(obs_ack[0]), 0);
    chk("fix_ack1", 32'(obs_ack[1]), 10);
    req = 4'h0;
    cyc();

    // counter wrap
    wr(A_STAT, 32'h0);
    wr(A_CTRL, 32'h000F_0101);
    req = 4'hF;
    g = 0;
    while (m_cnt != 65535 && g < 70000) begin cyc(); g++; end
    req = 4'h0;
    cyc();
    rd(A_STAT);
    chk("cnt_max", 32'(sw_rdata[15:0]), 32'h0000_FFFF);
    req = 4'b0001;
    cyc();
    req = 4'h0;
    rd(A_STAT);
    chk("cnt_wrap", 32'(sw_rdata[15:0]), 0);
    req = 4'hF; cyc(); cyc();
    wr(A_STAT, 32'h1234_5678);
    req = 4'h0;
    rd(A_STAT);
    chk("cnt_clr_wins", 32'(sw_rdata[15:0]), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      sw_re = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 2))
        0: sw_addr = A_CTRL;
        1: sw_addr = A_STAT;
        default: sw_addr = 32'h0000_0020;
      endcase
      sw_we = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        d = $urandom;
        d[15:8] = 8'($urandom_range(0, 5));
        d[0] = $urandom_range(0, 7) != 0;
        sw_we = 1'b1; sw_wdata = d;
        sw_addr = ($urandom_range(0, 3) == 0) ? A_STAT : A_CTRL;
      end
      cyc();
    end
    sw_we = 1'b0; sw_re = 1'b0; fifo_full = 1'b0;

    // reset in the middle of a burst
    req = 4'h0;
    wr(A_CTRL, 32'h000F_0801);
    req = 4'b0001;
    cyc(); cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_push", 32'(fifo_push), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_id", 32'(push_id), 0);
    chk("mid_rst_rdata", sw_rdata, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(A_CTRL);
    chk("post_rst_ctrl", sw_rdata, 0);
    repeat (3) cyc();
    rd(A_STAT);
    chk("post_rst_stat", sw_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
